// File: rtl/bus_read_master.sv
// bus_read_master
//   Initiator for the single-initiator read bus. Splits a core word-read
//   request (start address, word count) into bursts of at most MAX_BURST
//   beats, issues each burst only when the capture FIFO can hold all of it,
//   and streams the captured words to the core with valid/ready.
//
//   Optional feature, macro RD_MASTER_TIMEOUT_EN: a watchdog aborts a burst
//   that stalls for TIMEOUT_CYC cycles in REQ or DATA and sets the sticky
//   err flag. Without the macro the block waits indefinitely and err is 0.
//
// Ports
//   bus_clk, bus_rst    clock, asynchronous active-high reset
//   req_valid/req_ready core request handshake (ready only in IDLE)
//   req_addr, req_len   start word address, number of words (0 = no-op)
//   busy                high whenever not IDLE
//   ADDR_M, BLEN_M      burst address / beat count, valid while RVALID_M
//   RVALID_M, RREADY_M  bus request handshake
//   RDATA_M, RLAST_M    returned beat and end-of-burst marker
//   out_valid/out_ready show-ahead FIFO output handshake, data on out_data
//   err                 sticky watchdog error
//
// States
//   IDLE  | waiting for a core request
//   CHECK | waiting for FIFO room for the next burst
//   REQ   | RVALID_M held until RREADY_M
//   DATA  | capturing one beat per cycle until RLAST_M or blen beats
module bus_read_master #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int LEN_W       = 10,
  parameter int REQ_LEN_W   = 12,
  parameter int MAX_BURST   = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [REQ_LEN_W-1:0] req_len,
  output logic                 busy,
  output logic [ADDR_W-1:0]    ADDR_M,
  output logic [LEN_W-1:0]     BLEN_M,
  output logic                 RVALID_M,
  input  logic                 RREADY_M,
  input  logic [DATA_W-1:0]    RDATA_M,
  input  logic                 RLAST_M,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 out_ready,
  output logic                 err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  generate
    if (MAX_BURST < 1 || MAX_BURST > FIFO_DEPTH || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("bus_read_master: illegal MAX_BURST/FIFO_DEPTH/TIMEOUT_CYC");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_REQ, ST_DATA} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
  logic [REQ_LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];

  logic [LEN_W-1:0]     blen;
  logic [LEN_W-1:0]     free_slots;
  logic                 push, pop, burst_end;

  // remaining only changes at a burst end, so blen is stable through REQ/DATA
  assign blen = (remaining_q < REQ_LEN_W'(MAX_BURST)) ? LEN_W'(remaining_q)
                                                       : LEN_W'(MAX_BURST);
  // uses the registered count, so a pop this cycle only frees room next cycle
  assign free_slots = LEN_W'(FIFO_DEPTH) - LEN_W'(count_q);
  assign push      = (state_q == ST_DATA);
  assign pop       = out_ready && (count_q != '0);
  assign burst_end = push && (RLAST_M || (beat_q + LEN_W'(1) == blen));

`ifdef RD_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cur_addr_d  = req_addr;
          remaining_d = req_len;
          beat_d      = '0;
          if (req_len != '0) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (free_slots >= blen) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (RREADY_M) begin
          state_d = ST_DATA;
          beat_d  = '0;
        end
      end
      ST_DATA: begin
        beat_d = beat_q + LEN_W'(1);
        if (burst_end) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(blen);
          remaining_d = remaining_q - REQ_LEN_W'(blen);
          beat_d      = '0;
          state_d     = (remaining_q == REQ_LEN_W'(blen)) ? ST_IDLE : ST_CHECK;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef RD_MASTER_TIMEOUT_EN
    err_d = err_q;
    tmo_d = tmo_q;
    if (state_q == ST_IDLE && req_valid) err_d = 1'b0;
    // Down-counter reloads on every state change; reaching zero while still
    // stuck in REQ/DATA aborts the request. FIFO contents stay deliverable.
    if ((state_q == ST_REQ || state_q == ST_DATA) && state_d == state_q) begin
      if (tmo_q == '0) begin
        state_d     = ST_IDLE;
        remaining_d = '0;
        beat_d      = '0;
        err_d       = 1'b1;
      end else begin
        tmo_d = tmo_q - TMO_W'(1);
      end
    end else begin
      tmo_d = TMO_W'(TIMEOUT_CYC - 1);
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // storage needs no reset: count_q gates everything read from it
  always_ff @(posedge bus_clk) begin
    if (push) mem_q[wr_ptr_q] <= RDATA_M;
  end

`ifdef RD_MASTER_TIMEOUT_EN
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign RVALID_M  = (state_q == ST_REQ);
  assign ADDR_M    = RVALID_M ? cur_addr_q : '0;
  assign BLEN_M    = RVALID_M ? blen : '0;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: doc/bus_read_master.md
Name: bus_read_master

Overview:
- Bus initiator for the single-initiator read bus. It is the requesting end of the protocol that the ROM and other memory wrappers answer.
- Takes a word-read request (start address, word count) from a core-side engine and splits it into bursts of at most MAX_BURST beats.
- Issues each burst on the bus, captures the returned beats into an internal FIFO, and streams them to the core with valid/ready backpressure.
- Never stalls the bus data phase. A burst is issued only when the FIFO has room for the whole burst.

Parameters:
ADDR_W, 12, bus address width (equals BUS_ADDR_BITS)
DATA_W, 16, bus data width (equals BUS_DATA_BITS)
LEN_W, 10, bus burst-length field width (equals BUS_LEN_BITS)
REQ_LEN_W, 12, core request word-count width
MAX_BURST, 4, maximum beats per bus burst (1..FIFO_DEPTH)
FIFO_DEPTH, 8, capture FIFO depth in words (power of 2)
TIMEOUT_CYC, 16, handshake watchdog limit (used only with the optional feature)

Ports:
bus_clk  in  1  clock
bus_rst  in  1  reset, asynchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  high in IDLE only
req_addr  in  ADDR_W  start word address
req_len  in  REQ_LEN_W  number of words
busy  out  1  high whenever state is not IDLE
ADDR_M  out  ADDR_W  bus address, valid while RVALID_M is high
BLEN_M  out  LEN_W  beats in this burst (1 means one beat)
RVALID_M  out  1  bus read request
RREADY_M  in  1  responder handshake
RDATA_M  in  DATA_W  responder data
RLAST_M  in  1  final beat of burst
out_valid  out  1  FIFO not empty
out_data  out  DATA_W  FIFO head (show-ahead)
out_ready  in  1  core pop
err  out  1  sticky timeout error

Behaviour:
- Reset (asynchronous, any state, including mid-burst):
  - state=IDLE; FIFO emptied.
  - RVALID_M=0, ADDR_M=0, BLEN_M=0, out_valid=0, busy=0, err=0, req_ready=1.
  - Internal addr/remaining/beat counters cleared.
- States: IDLE, CHECK, REQ, DATA.
- IDLE:
  - req_ready=1.
  - On req_valid: latch cur_addr=req_addr, remaining=req_len, and clear err.
  - If req_len==0: accepted as a no-op; stay IDLE with no bus activity. Otherwise go to CHECK.
- CHECK:
  - blen = min(remaining, MAX_BURST).
  - Go to REQ when FIFO free slots (FIFO_DEPTH - count) >= blen; otherwise stay in CHECK.
  - A pop in the same cycle does not count toward free slots until the next cycle.
- REQ:
  - RVALID_M=1, ADDR_M=cur_addr, BLEN_M=blen, all held stable.
  - Go to DATA on the first cycle RREADY_M=1 is sampled.
- DATA:
  - RVALID_M=0.
  - Every cycle: push RDATA_M into the FIFO, beat count +1.
  - Burst ends on RLAST_M=1, or when the beat count reaches blen, whichever comes first.
  - Beats after RLAST_M are ignored.
- End of burst:
  - cur_addr += blen, modulo 2^ADDR_W; wraps 4095 to 0 with no error.
  - remaining -= blen.
  - remaining==0 → IDLE; otherwise → CHECK.
- FIFO:
  - Push and pop in the same cycle are allowed at any level.
  - Overflow is impossible by construction. Pop when empty is ignored.
  - Words are delivered in request address order.
- Latency with a ROM-style responder (RREADY one cycle after RVALID, data on the next cycle), request accepted at edge T:
  - CHECK at T+1, RVALID_M at T+2, RREADY_M seen at T+3.
  - First beat captured at T+4; out_valid=1 at T+5.
- A new request is accepted in IDLE even while the FIFO still holds data from the previous request.

Optional Feature:
- Macro: RD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and DATA.
  - If REQ lasts TIMEOUT_CYC cycles without RREADY_M, or DATA lasts TIMEOUT_CYC cycles without ending: drop RVALID_M, set err=1, discard remaining, go to IDLE.
  - Beats already in the FIFO remain deliverable.
- Not defined:
  - No counter; the block waits indefinitely.
  - err is tied to 0.

Test Plan:
- Single word: req_addr=0x010, req_len=1, ROM-style responder, out_ready=1 → one RVALID_M pulse group with ADDR_M=0x010, BLEN_M=1; out_valid at T+5 with ROM[0x010]; busy drops after RLAST_M.
- Split burst: req_addr=0x100, req_len=10, MAX_BURST=4 → bursts (0x100,4), (0x104,4), (0x108,2); 10 words out in address order.
- Backpressure: req_len=16 with out_ready=0 → at most 8 words captured; block holds in CHECK with RVALID_M=0; raising out_ready resumes and delivers all 16 with no loss or duplication.
- Wrap and no-op: req_addr=0xFFE, req_len=4 → one burst ADDR_M=0xFFE, BLEN_M=4, next cur_addr=0x002; separately req_len=0 → no RVALID_M, busy stays 0.
- Reset mid-DATA: assert bus_rst on the second beat → out_valid=0, RVALID_M=0 immediately; after release a new request completes correctly.
- Timeout (RD_MASTER_TIMEOUT_EN defined): responder never raises RREADY_M → RVALID_M drops after 16 cycles, err=1, state IDLE; err clears on the next request accept.
